// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache between the core load/store port
// and main memory. Owns the memory request/mem_done handshake, including a stretched mem_done.
module cache_controller #(
  parameter int RISC_data = 32,
  parameter int main_data = 128,
  parameter int ADDR_W    = 10,
  parameter int INDEX_W   = 5,
  parameter int DRAIN     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [RISC_data-1:0]  cpu_wdata,
  output logic [RISC_data-1:0]  cpu_rdata,
  output logic                  stall,
  output logic                  mem_RE,
  output logic                  mem_WE,
  output logic [ADDR_W-3:0]     mem_A,
  output logic [1:0]            mem_word_loc,
  output logic [RISC_data-1:0]  mem_WD,
  input  logic [main_data-1:0]  mem_RD,
  input  logic                  mem_done
);

  localparam int TAG_W   = ADDR_W - 2 - INDEX_W;
  localparam int LINES   = 1 << INDEX_W;
  localparam int WORD_SH = $clog2(RISC_data);
  localparam int CNT_W   = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  localparam logic [2:0] S_DRAIN   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_RD_MISS = 3'd2;
  localparam logic [2:0] S_WR_THRU = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  logic [2:0]           state;
  logic [CNT_W-1:0]     drain_cnt;
  logic                 op_rd;
  logic [LINES-1:0]     valid;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [main_data-1:0] line_mem [LINES];

  logic [INDEX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]     cpu_tag;
  logic [1:0]           cpu_off;
  logic [INDEX_W-1:0]   req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic                 hit;
  logic [RISC_data-1:0] hit_word;
  logic [RISC_data-1:0] req_word;

  function automatic logic [RISC_data-1:0] word_sel(input logic [main_data-1:0] ln,
                                                    input logic [1:0] off);
    return ln[{off, {WORD_SH{1'b0}}} +: RISC_data];
  endfunction

  assign cpu_idx  = cpu_addr[INDEX_W+1:2];
  assign cpu_tag  = cpu_addr[ADDR_W-1:INDEX_W+2];
  assign cpu_off  = cpu_addr[1:0];
  // The registered line address doubles as the index/tag of the outstanding request.
  assign req_idx  = mem_A[INDEX_W-1:0];
  assign req_tag  = mem_A[ADDR_W-3:INDEX_W];
  assign hit      = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign hit_word = word_sel(line_mem[cpu_idx], cpu_off);
  assign req_word = word_sel(line_mem[req_idx], mem_word_loc);

  always_comb begin
    stall     = 1'b1;
    cpu_rdata = '0;
    case (state)
      S_IDLE: begin
        if (!cpu_wr && (!cpu_rd || hit)) stall = 1'b0;
        if (!cpu_wr && cpu_rd && hit) cpu_rdata = hit_word;
      end
      S_RESP: begin
        if (op_rd) begin
          stall     = 1'b0;
          cpu_rdata = req_word;
        end else if (cpu_rd) begin
          // A load that arrived together with this store is answered now if it hits.
          if (hit) begin
            stall     = 1'b0;
            cpu_rdata = hit_word;
          end
        end else begin
          stall = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_DRAIN;
      drain_cnt    <= CNT_W'(DRAIN - 1);
      op_rd        <= 1'b0;
      valid        <= '0;
      mem_RE       <= 1'b0;
      mem_WE       <= 1'b0;
      mem_A        <= '0;
      mem_word_loc <= '0;
      mem_WD       <= '0;
    end else begin
      case (state)
        S_DRAIN: begin
          if (drain_cnt == '0) state <= S_IDLE;
          else drain_cnt <= drain_cnt - 1'b1;
        end
        S_IDLE: begin
          if (cpu_wr) begin
            mem_A        <= cpu_addr[ADDR_W-1:2];
            mem_word_loc <= cpu_off;
            mem_WD       <= cpu_wdata;
            mem_WE       <= 1'b1;
            op_rd        <= 1'b0;
            state        <= S_WR_THRU;
          end else if (cpu_rd && !hit) begin
            mem_A        <= cpu_addr[ADDR_W-1:2];
            mem_word_loc <= cpu_off;
            mem_RE       <= 1'b1;
            op_rd        <= 1'b1;
            state        <= S_RD_MISS;
          end
        end
        S_RD_MISS: begin
          if (mem_done) begin
            valid[req_idx] <= 1'b1;
            mem_RE         <= 1'b0;
            state          <= S_RELEASE;
          end
        end
        S_WR_THRU: begin
          if (mem_done) begin
            mem_WE <= 1'b0;
            state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!mem_done) state <= S_RESP;
        end
        S_RESP: begin
          if (!op_rd && cpu_rd && !hit) begin
            mem_A        <= cpu_addr[ADDR_W-1:2];
            mem_word_loc <= cpu_off;
            mem_RE       <= 1'b1;
            op_rd        <= 1'b1;
            state        <= S_RD_MISS;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_DRAIN;
      endcase
    end
  end

  // Line contents and tags carry no reset; the valid bits alone decide whether they count.
  always_ff @(posedge clk) begin
    if (state == S_RD_MISS && mem_done) begin
      line_mem[req_idx] <= mem_RD;
      tag_mem[req_idx]  <= req_tag;
    end else if (state == S_IDLE && cpu_wr && hit) begin
      line_mem[cpu_idx][{cpu_off, {WORD_SH{1'b0}}} +: RISC_data] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed scenarios plus random traffic against a word-level
// memory image and a direct-mapped valid/tag model.
module tb_cache_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_rd, cpu_wr;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         stall, mem_RE, mem_WE;
  logic [7:0]   mem_A;
  logic [1:0]   mem_word_loc;
  logic [31:0]  mem_WD;
  logic [127:0] mem_RD = '0;
  logic         mem_done = 1'b0;

  int errors = 0;
  int checks = 0;
  int mem_lat = 4;
  int done_len = 2;
  logic [31:0] salt = 32'h0;

  logic [31:0] ref_mem [1024];
  bit          ref_valid [32];
  logic [2:0]  ref_tag [32];

  cache_controller dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .mem_RE(mem_RE),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_word_loc(mem_word_loc), .mem_WD(mem_WD),
    .mem_RD(mem_RD), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [9:0] a);
    return ({22'd0, a} * 32'h9E3779B1) ^ salt;
  endfunction

  // Main-memory stand-in: mem_lat cycles of request, then mem_done held for done_len cycles.
  logic [127:0] mem_line [256];
  bit mem_init = 1'b0;
  int wcnt = 0;
  int hold = 0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++)
        for (int k = 0; k < 4; k++)
          mem_line[i][k*32 +: 32] <= init_word(10'(i*4 + k));
      mem_init <= 1'b1;
    end
    if (hold > 0) begin
      hold <= hold - 1;
      if (hold == 1) mem_done <= 1'b0;
    end else if (mem_RE || mem_WE) begin
      if (wcnt + 1 >= mem_lat) begin
        mem_done <= 1'b1;
        hold     <= done_len;
        wcnt     <= 0;
        if (mem_RE) mem_RD <= mem_line[mem_A];
        if (mem_WE) mem_line[mem_A][mem_word_loc*32 +: 32] <= mem_WD;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // Sticky protocol flag: both requests at once, or a read request rising during mem_done.
  bit proto_bad = 1'b0;
  logic prev_re = 1'b0;
  always @(negedge clk) begin
    if (mem_RE === 1'b1 && mem_WE === 1'b1) proto_bad <= 1'b1;
    if (mem_RE === 1'b1 && prev_re === 1'b0 && mem_done) proto_bad <= 1'b1;
    prev_re <= mem_RE;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_hit(input logic [9:0] a);
    return ref_valid[a[6:2]] && (ref_tag[a[6:2]] == a[9:7]);
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
  endtask

  // Called one time unit after a posedge; samples the drain from the next negedge.
  task automatic wait_drain();
    int cyc = 0;
    @(negedge clk);
    check("drain_no_re", mem_RE, 1'b0);
    check("drain_no_we", mem_WE, 1'b0);
    while (stall && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("drain_cycles", cyc, 8);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [9:0] a);
    int cyc = 0, re_cyc = 0, exp_st;
    bit a_ok = 1'b1, z_ok = 1'b1, h;
    h = ref_hit(a);
    exp_st = h ? 0 : mem_lat + 2 + done_len;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
    @(negedge clk);
    while (stall && cyc < 100) begin
      if (mem_RE) begin
        re_cyc++;
        if (mem_A !== a[9:2] || mem_word_loc !== a[1:0]) a_ok = 1'b0;
      end
      if (mem_WE) a_ok = 1'b0;
      if (cpu_rdata !== 32'h0) z_ok = 1'b0;
      cyc++;
      @(negedge clk);
    end
    check("rd_latency", cyc, exp_st);
    check("rd_data", cpu_rdata, ref_mem[a]);
    check("rd_req_ok", {a_ok, z_ok}, 2'b11);
    check("rd_re_cycles", re_cyc, h ? 0 : mem_lat + 1);
    ref_valid[a[6:2]] = 1'b1;
    ref_tag[a[6:2]]   = a[9:7];
    @(posedge clk); #1;
    cpu_rd = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input bit with_rd);
    int cyc = 0, we_cyc = 0, exp_st;
    bit a_ok = 1'b1, z_ok = 1'b1;
    exp_st = mem_lat + 2 + done_len;
    cpu_wr = 1'b1; cpu_rd = with_rd; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    while (stall && cyc < 100) begin
      if (mem_WE) begin
        we_cyc++;
        if (mem_A !== a[9:2] || mem_word_loc !== a[1:0] || mem_WD !== d) a_ok = 1'b0;
      end
      if (mem_RE) a_ok = 1'b0;
      if (cpu_rdata !== 32'h0) z_ok = 1'b0;
      cyc++;
      @(negedge clk);
    end
    ref_mem[a] = d;
    check("wr_latency", cyc, exp_st);
    check("wr_req_ok", {a_ok, z_ok}, 2'b11);
    check("wr_we_cycles", we_cyc, mem_lat + 1);
    check("wr_resp_rdata", cpu_rdata, with_rd ? d : 32'h0);
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  initial begin
    salt = $urandom;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
    ref_reset();
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset values
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_stall", stall, 1'b1);
    check("rst_req", {mem_RE, mem_WE}, 2'b00);
    check("rst_addr", {mem_A, mem_word_loc}, 10'h0);
    check("rst_wd", mem_WD, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_drain();

    // First miss, then hit on the neighbouring word
    do_read(10'h004);
    do_read(10'h005);

    // Store hit, then readback
    do_write(10'h006, 32'hDEADBEEF, 1'b0);
    do_read(10'h006);
    check("store_hit_value", ref_mem[10'h006], 32'hDEADBEEF);

    // Store miss does not allocate
    do_write(10'h3F0, 32'h12345678, 1'b0);
    check("nwa_predict_miss", ref_hit(10'h3F0), 1'b0);
    do_read(10'h3F0);

    // Conflict on index 1
    do_read(10'h004);
    do_read(10'h084);
    do_read(10'h004);

    // Single-cycle mem_done, then concurrent load+store on a cached word
    done_len = 1;
    do_read(10'h008);
    done_len = 2;
    do_write(10'h005, 32'hCAFEF00D, 1'b1);
    do_read(10'h005);

    // Reset during a line fill
    cpu_rd = 1'b1; cpu_addr = 10'h084;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("fill_active", mem_RE, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; cpu_rd = 1'b0;
    ref_reset();
    wait_drain();
    check("post_rst_predict", ref_hit(10'h004), 1'b0);
    do_read(10'h004);

    // Random traffic over a small address window to mix hits, misses and conflicts
    for (int n = 0; n < 40; n++) begin
      logic [9:0] a;
      logic [31:0] d;
      int op;
      mem_lat  = $urandom_range(1, 5);
      done_len = $urandom_range(1, 2);
      a  = {3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      d  = $urandom;
      op = $urandom_range(0, 2);
      if (op == 0) do_read(a);
      else if (op == 1 || !ref_hit(a)) do_write(a, d, 1'b0);
      else do_write(a, d, 1'b1);
    end

    check("protocol", proto_bad, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
